// File: rtl/layer_mac_pkg.sv
// Shared types and constants for the time-multiplexed fully-connected layer scheduler.
// Q8.16 activations/weights; the accumulator carries full-precision products.
package layer_mac_pkg;

  localparam int N_IN   = 30;
  localparam int N_OUT  = 15;
  localparam int W      = 24;
  localparam int FRAC   = 16;
  localparam int ACC_W  = 2 * W + 6;

  localparam int SEL_W  = $clog2(N_IN);
  localparam int I_W    = $clog2(N_IN + 1);
  localparam int ADDR_W = $clog2(N_OUT * (N_IN + 1));
  localparam int IDX_W  = $clog2(N_OUT);

  localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W){1'b0}}, OUT_MAX};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W){1'b1}}, OUT_MIN};

  // Operand substituted for the activation on the bias term: 1.0 in Q8.16.
  localparam logic signed [W-1:0] BIAS_ONE = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_e;

  // Rescale the accumulator back to Q8.16 (floor) and clamp to the W-bit signed range.
  function automatic logic [W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > SAT_MAX)      return OUT_MAX;
    else if (sh < SAT_MIN) return OUT_MIN;
    return sh[W-1:0];
  endfunction

endpackage

// File: rtl/layer_mac_sched_mac_unit.sv
// Shared multiply-accumulate: registered activation operand, signed W x W product,
// sign-extended accumulate with synchronous clear (priority) and accumulate-enable.
module mac_unit
  import layer_mac_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_en,
  input  logic signed [W-1:0]     op_in,
  input  logic signed [W-1:0]     w_in,
  input  logic                    clr,
  input  logic                    acc_en,
  output logic signed [ACC_W-1:0] acc_next_o
);

  logic signed [W-1:0]     op_q, op_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] sum;

  assign prod       = op_q * w_in;
  assign sum        = acc_q + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
  assign acc_next_o = sum;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_d  = op_q;
    acc_d = acc_q;
    if (op_en) op_d = op_in;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = sum;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      acc_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/layer_mac_sched.sv
// Sequences one shared MAC over every node of a fully-connected layer.
// Build option: define LAYER_MAC_SCHED_RELU_EN to clamp negative results to zero.
module layer_mac_sched
  import layer_mac_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [SEL_W-1:0]      in_sel,
  input  logic signed [W-1:0]   in_data,
  output logic [ADDR_W-1:0]     w_addr,
  input  logic signed [W-1:0]   w_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [W-1:0]          out_data
);

  localparam logic [I_W-1:0]   LAST_I    = I_W'(N_IN);
  localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(N_OUT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   node_q, node_d;
  logic [I_W-1:0]     i_q, i_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [SEL_W-1:0]   in_sel_q, in_sel_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [W-1:0]       out_data_q, out_data_d;

  logic                    op_en, acc_clr, acc_en;
  logic signed [W-1:0]     op_in;
  logic signed [ACC_W-1:0] acc_next;
  logic [W-1:0]            result;

  assign op_in = (i_q == LAST_I) ? BIAS_ONE : in_data;

  mac_unit u_mac (
    .clk        (clk),
    .reset      (reset),
    .op_en      (op_en),
    .op_in      (op_in),
    .w_in       (w_data),
    .clr        (acc_clr),
    .acc_en     (acc_en),
    .acc_next_o (acc_next)
  );

  always_comb begin
    result = sat_shift(acc_next);
`ifdef LAYER_MAC_SCHED_RELU_EN
    if (result[W-1]) result = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    i_d         = i_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    in_sel_d    = in_sel_q;
    w_addr_d    = w_addr_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    op_en       = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_MAC;
          node_d   = '0;
          i_d      = '0;
          busy_d   = 1'b1;
          in_sel_d = '0;
          w_addr_d = '0;
          acc_clr  = 1'b1;
        end
      end
      S_MAC: begin
        // Products lag issue by one cycle, so the i=0 cycle has nothing to add yet.
        op_en  = 1'b1;
        acc_en = (i_q != '0);
        if (i_q == LAST_I) begin
          state_d = S_DRAIN;
        end else begin
          i_d      = i_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
          in_sel_d = (i_q + 1'b1 == LAST_I) ? '0 : SEL_W'(i_q + 1'b1);
        end
      end
      S_DRAIN: begin
        acc_en      = 1'b1;
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        out_idx_d   = node_q;
        out_data_d  = result;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (node_q == LAST_NODE) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = S_MAC;
            node_d   = node_q + 1'b1;
            i_d      = '0;
            in_sel_d = '0;
            w_addr_d = w_addr_q + 1'b1;
            acc_clr  = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      node_q      <= '0;
      i_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_sel_q    <= '0;
      w_addr_q    <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      i_q         <= i_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      in_sel_q    <= in_sel_d;
      w_addr_q    <= w_addr_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign in_sel    = in_sel_q;
  assign w_addr    = w_addr_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_layer_mac_sched.sv
// Directed bench for layer_mac_sched: table of uniform-pattern layer passes plus
// hand-written stall, mid-pass reset and ignored-start sequences.
module tb_layer_mac_sched;

  localparam int NI = 30;
  localparam int NO = 15;
  localparam int BASE_LAT = 496;

  logic             clk;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic [4:0]       in_sel;
  logic signed [23:0] in_data;
  logic [8:0]       w_addr;
  logic signed [23:0] w_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_idx;
  logic [23:0]      out_data;

  logic [23:0] act [32];
  logic [23:0] rom [512];
  logic [23:0] exp_q [NO];

  int checks   = 0;
  int failures = 0;

  layer_mac_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign in_data = act[in_sel];
  always @(posedge clk) w_data <= rom[w_addr];

  typedef struct {
    logic [23:0] act;
    logic [23:0] wt;
    logic [23:0] bias;
    bit          ramp;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 32; k++) act[k] = v.act;
    for (int k = 0; k < 512; k++) rom[k] = '0;
    for (int n = 0; n < NO; n++) begin
      for (int k = 0; k < NI; k++) rom[n*(NI+1)+k] = v.wt;
      rom[n*(NI+1)+NI] = v.ramp ? 24'(n * 32'h10000) : v.bias;
      exp_q[n] = v.ramp ? 24'(n * 32'h10000) : v.exp;
`ifdef LAYER_MAC_SCHED_RELU_EN
      if (exp_q[n][23]) exp_q[n] = '0;
`endif
    end
  endtask

  // One full pass: optional back-pressure on one node, optional start pokes while busy / in FIN.
  task automatic run_pass(input string tag, input int stall_node, input int stall_n, input bit poke);
    int cyc;
    int hs;
    int stall_left;
    int extra_done;
    hs = 0;
    stall_left = stall_n;
    extra_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    cyc = 1;
    while (cyc < 3000) begin
      if (done) break;
      if (out_valid) begin
        if (hs < NO) begin
          check({tag, " out_idx"}, 32'(out_idx), 32'(hs));
          check({tag, " out_data"}, 32'(out_data), 32'(exp_q[hs]));
        end
        if (int'(out_idx) == stall_node && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          check({tag, " busy in stall"}, 32'(busy), 32'd1);
        end else begin
          out_ready = 1'b1;
          hs++;
        end
      end else begin
        out_ready = 1'b1;
      end
      start = (poke && cyc == 100);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, " done latency"}, 32'(cyc), 32'(BASE_LAT + stall_n));
    check({tag, " handshakes"}, 32'(hs), 32'(NO));
    check({tag, " busy low with done"}, 32'(busy), 32'd0);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check({tag, " idle after pass"}, 32'(extra_done), 32'd0);
  endtask

  initial begin
    int hs;
    int bad;

    vecs[0] = '{act: 24'h010000, wt: 24'h008000, bias: 24'h000000, ramp: 1'b0, exp: 24'h0F0000};
    vecs[1] = '{act: 24'h010000, wt: 24'h000000, bias: 24'h000000, ramp: 1'b1, exp: 24'h000000};
    vecs[2] = '{act: 24'h7FFFFF, wt: 24'h7FFFFF, bias: 24'h7FFFFF, ramp: 1'b0, exp: 24'h7FFFFF};
    vecs[3] = '{act: 24'h7FFFFF, wt: 24'h800001, bias: 24'h800001, ramp: 1'b0, exp: 24'h800000};
    vecs[4] = '{act: 24'hFF0000, wt: 24'h020000, bias: 24'h008000, ramp: 1'b0, exp: 24'hC48000};
    vecs[5] = '{act: 24'h000001, wt: 24'hFFFFFF, bias: 24'h000000, ramp: 1'b0, exp: 24'hFFFFFF};
    vecs[6] = '{act: 24'h000001, wt: 24'h000001, bias: 24'h000000, ramp: 1'b0, exp: 24'h000000};

    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    load_vec(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst busy",      32'(busy),      32'd0);
    check("rst done",      32'(done),      32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_sel",    32'(in_sel),    32'd0);
    check("rst w_addr",    32'(w_addr),    32'd0);
    check("rst out_idx",   32'(out_idx),   32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      load_vec(vecs[v]);
      run_pass($sformatf("vec%0d", v), -1, 0, 1'b0);
    end

    load_vec(vecs[0]);
    run_pass("stall", 3, 5, 1'b0);

    load_vec(vecs[4]);
    run_pass("poke", -1, 0, 1'b1);

    // Abort during node 7 accumulation, then confirm a clean restart.
    load_vec(vecs[0]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hs = 0;
    for (int k = 0; k < 1000 && hs < 7; k++) begin
      if (out_valid) hs++;
      @(negedge clk);
    end
    check("abort reached node7", 32'(hs), 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort busy",      32'(busy),      32'd0);
    check("abort done",      32'(done),      32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_sel",    32'(in_sel),    32'd0);
    check("abort w_addr",    32'(w_addr),    32'd0);
    check("abort out_idx",   32'(out_idx),   32'd0);
    check("abort out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy || out_valid) bad++;
    end
    check("abort no done", 32'(bad), 32'd0);
    load_vec(vecs[1]);
    run_pass("restart", -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_mac_sched.md
# layer_mac_sched

Time-multiplexed scheduler for one fully-connected layer: replaces per-node parallel neurons with a single shared multiply-accumulate, sequencing input select, weight-ROM address and accumulation for every output node in turn. Sits between the previous layer's registered 24-bit activation bus (external mux driven by `in_sel`) and the next layer's output register file (written through the `out_*` handshake). One `start` computes all nodes; `done` marks completion.

## Interface
- `N_IN`, 30: inputs per node.
- `N_OUT`, 15: output nodes.
- `W`, 24: activation/weight width, signed two's complement.
- `FRAC`, 16: fractional bits (Q8.16).
- `ACC_W`, 2*W+6: accumulator width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one layer pass; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last node's output handshake.
- `in_sel`  out  $clog2(N_IN)  index of activation to present on `in_data`.
- `in_data`  in  W  selected activation, combinational from `in_sel`.
- `w_addr`  out  $clog2(N_OUT*(N_IN+1))  weight-ROM address, node*(N_IN+1)+i; i=N_IN is the bias.
- `w_data`  in  W  ROM data, valid exactly one cycle after `w_addr`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_idx`  out  $clog2(N_OUT)  node number of result, 0-based.
- `out_data`  out  W  node result.

## Operation
- States: IDLE, MAC, DRAIN, OUT, FIN.
- IDLE: all outputs idle; `start`=1 -> MAC with node=0, i=0, accumulator cleared.
- MAC: each cycle issue `w_addr`=node*(N_IN+1)+i, `in_sel`=i (i=N_IN: `in_sel` holds 0, operand forced to 1<<FRAC); i increments; after issuing i=N_IN -> DRAIN.
- Operand pipeline: `in_data` registered alongside issue so it aligns with `w_data` next cycle; product W×W->2W signed, added sign-extended to ACC_W accumulator.
- DRAIN: accumulate final (bias) product -> OUT.
- OUT: `out_data` = saturate(acc >>> FRAC) to W-bit signed range [-2^(W-1), 2^(W-1)-1], arithmetic shift, truncation toward -inf; `out_valid`=1, `out_idx`=node. Held stable until `out_ready`. On handshake: node==N_OUT-1 -> FIN, else node+1, i=0, acc cleared -> MAC.
- FIN: `done`=1 for one cycle, `busy` falls same cycle -> IDLE.
- `start` while not IDLE ignored. `start` in FIN cycle ignored; accepted from next IDLE cycle.
- `reset` asserted mid-pass: immediate return to IDLE, pass aborted, no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `in_sel`=0, `w_addr`=0, `out_idx`=0, `out_data`=0, accumulator 0, state IDLE.
- `start` high at edge k -> `busy`=1 and first `w_addr` at k+1.
- Per node with `out_ready` tied high: N_IN+1 MAC + 1 DRAIN + 1 OUT = N_IN+3 cycles (33 default).
- Full pass, `out_ready` high: N_OUT*(N_IN+3)+1 cycles from `start` to `done` (496 default).
- Each low `out_ready` cycle adds exactly one cycle; no ROM address issued during OUT.
- Outputs registered; no combinational path `out_ready` -> `out_valid`.

## Configuration
- `LAYER_MAC_SCHED_RELU_EN` defined: negative saturated results replaced by 0 before `out_data`.
- Undefined: signed saturated result passed unmodified (linear layer).

## Structure
- Package `layer_mac_pkg`: state enum, default N_IN/N_OUT/W/FRAC, ACC_W derivation, saturation limit constants.
- Sub-module `mac_unit`: registered signed multiply, ACC_W accumulate, synchronous clear, accumulate-enable; scheduler drives clear/enable only.

## Test plan
- All activations 1.0 (0x010000), all weights 0.5 (0x008000), bias 0 -> every node outputs 15.0 (0x0F0000); `out_idx` 0..14 in order; `done` 496 cycles after `start`.
- Weights 0, bias node n = n×0x010000 -> `out_data` = n×0x010000 for each node.
- Activations 0x7FFFFF, weights 0x7FFFFF -> positive saturation 0x7FFFFF; negate weights -> 0x800000 (0 with RELU_EN).
- `out_ready` low 5 cycles at node 3 -> `out_valid`, `out_data`, `out_idx`=3 held stable; `done` delayed exactly 5 cycles.
- `reset` low during node 7 MAC -> all outputs at reset values next cycle, no `done`; subsequent `start` restarts at node 0 with correct results.
- `start` pulsed while `busy` and in FIN cycle -> ignored; exactly one `done`, 15 handshakes.
